// File: rtl/pipeline_run_monitor.sv
// pipeline_run_monitor: run controller and sort checker for the pipelined RISC-V core.
//   Sequences the core reset, counts RUN cycles and stall/flush events, and ends a run
//   with pass (element taps ordered and unchanged for STABLE_CYCLES cycles) or timeout.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   start      in   1-cycle pulse, begins a run from IDLE or DONE
//   elements   in   NUM_ELEM taps, element i at [i*DATA_W +: DATA_W]
//   stall      in   core stall indicator
//   flush      in   core flush indicator
//   core_reset out  active-high reset to the core
//   busy       out  1 in RESET or RUN
//   done       out  1 in DONE
//   pass       out  run ended sorted and stable
//   timeout    out  run ended by TIMEOUT
//   cycle_cnt  out  RUN cycles elapsed
//   stall_cnt  out  RUN cycles with stall=1
//   flush_cnt  out  RUN cycles with flush=1
module pipeline_run_monitor #(
    parameter int DATA_W        = 64,
    parameter int NUM_ELEM      = 8,
    parameter int CNT_W         = 32,
    parameter int RST_CYCLES    = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT       = 700,
    parameter bit ASCENDING     = 1'b1,
    parameter bit SIGNED_CMP    = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_ELEM*DATA_W-1:0]   elements,
    input  logic                         stall,
    input  logic                         flush,
    output logic                         core_reset,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic [CNT_W-1:0]             cycle_cnt,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             flush_cnt
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

    state_t                       state;
    logic [NUM_ELEM*DATA_W-1:0]   snapshot;
    logic                         snap_valid;
    logic [SW-1:0]                stable_cnt;
    logic [RW-1:0]                rst_cnt;
    logic                         sorted;
    logic                         stable_hit;
    logic [SW-1:0]                stable_nxt;
    logic [CNT_W-1:0]             cycle_nxt;
    logic [CNT_W-1:0]             stall_nxt;
    logic [CNT_W-1:0]             flush_nxt;

    // Equal neighbours are always in order.
    function automatic logic in_order(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic a_gt_b;
        logic a_lt_b;
        a_gt_b = SIGNED_CMP ? ($signed(a) > $signed(b)) : (a > b);
        a_lt_b = SIGNED_CMP ? ($signed(a) < $signed(b)) : (a < b);
        return ASCENDING ? !a_gt_b : !a_lt_b;
    endfunction

    always_comb begin
        sorted = 1'b1;
        for (int i = 0; i < NUM_ELEM - 1; i++)
            sorted = sorted & in_order(elements[i*DATA_W +: DATA_W], elements[(i+1)*DATA_W +: DATA_W]);
    end

    // The snapshot only becomes meaningful after the first RUN cycle has loaded it.
    assign stable_hit = sorted && snap_valid && (elements == snapshot);
    assign stable_nxt = stable_hit ? stable_cnt + 1'b1 : '0;
    assign cycle_nxt  = &cycle_cnt ? cycle_cnt : cycle_cnt + 1'b1;
    assign stall_nxt  = (stall && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
    assign flush_nxt  = (flush && !(&flush_cnt)) ? flush_cnt + 1'b1 : flush_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            snapshot   <= '0;
            snap_valid <= 1'b0;
            stable_cnt <= '0;
            rst_cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RST;
                        core_reset <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        timeout    <= 1'b0;
                        cycle_cnt  <= '0;
                        stall_cnt  <= '0;
                        flush_cnt  <= '0;
                        snap_valid <= 1'b0;
                        stable_cnt <= '0;
                        rst_cnt    <= '0;
                    end
                end
                RST: begin
                    rst_cnt <= rst_cnt + 1'b1;
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                    end
                end
                RUN: begin
                    cycle_cnt  <= cycle_nxt;
                    stall_cnt  <= stall_nxt;
                    flush_cnt  <= flush_nxt;
                    snapshot   <= elements;
                    snap_valid <= 1'b1;
                    stable_cnt <= stable_nxt;
                    // Pass is checked first so it wins a same-cycle tie with timeout.
                    if (stable_nxt == SW'(STABLE_CYCLES)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (cycle_nxt == CNT_W'(TIMEOUT)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_run_monitor.sv
// tb_pipeline_run_monitor: directed self-checking bench for pipeline_run_monitor.
module tb_pipeline_run_monitor;
    typedef int vec_t [8];

    logic          clk = 1'b0;
    logic          reset;
    logic          start, start2;
    logic          stall, flush;
    logic [511:0]  elements, elements2;
    logic [63:0]   e1 [8];
    logic [63:0]   e2 [8];
    logic          core_reset, busy, done, pass, timeout;
    logic [31:0]   cycle_cnt, stall_cnt, flush_cnt;
    logic          core_reset2, busy2, done2, pass2, timeout2;
    logic [31:0]   cycle_cnt2, stall_cnt2, flush_cnt2;
    int            n_checks = 0;
    int            n_fail = 0;
    int            n;

    always #5 clk = ~clk;

    always_comb begin
        elements  = '0;
        elements2 = '0;
        for (int i = 0; i < 8; i++) begin
            elements[i*64 +: 64]  = e1[i];
            elements2[i*64 +: 64] = e2[i];
        end
    end

    pipeline_run_monitor dut (
        .clk(clk), .reset(reset), .start(start), .elements(elements),
        .stall(stall), .flush(flush), .core_reset(core_reset), .busy(busy),
        .done(done), .pass(pass), .timeout(timeout), .cycle_cnt(cycle_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Timeout equal to the pass latency forces a same-cycle tie; descending signed order.
    pipeline_run_monitor #(.TIMEOUT(20), .STABLE_CYCLES(19), .ASCENDING(1'b0), .SIGNED_CMP(1'b1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .elements(elements2),
        .stall(1'b0), .flush(1'b0), .core_reset(core_reset2), .busy(busy2),
        .done(done2), .pass(pass2), .timeout(timeout2), .cycle_cnt(cycle_cnt2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load1_ramp(input bit up);
        for (int i = 0; i < 8; i++) e1[i] = up ? 64'(i + 1) : 64'(8 - i);
    endtask

    task automatic load2(input vec_t v);
        for (int i = 0; i < 8; i++) e2[i] = longint'(v[i]);
    endtask

    task automatic start1();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_c1_core_reset", core_reset, 1);
        check("rst_c1_busy", busy, 1);
        check("rst_c1_done", done, 0);
        check("restart_cycle_cnt", cycle_cnt, 0);
        check("restart_stall_cnt", stall_cnt, 0);
        check("restart_flags", {pass, timeout}, 0);
        @(negedge clk);
        check("rst_c2_core_reset", core_reset, 1);
        @(negedge clk);
        check("run_core_reset", core_reset, 0);
        check("run_busy", busy, 1);
    endtask

    // mode 0: static inputs plus an ignored start pulse; mode 1: swaps, stall and flush patterns.
    task automatic run1(input int limit, input int mode, output int cycles);
        int k = 0;
        while (!done && k < limit) begin
            if (mode == 0) begin
                start = (k == 5);
                stall = 1'b0;
                flush = 1'b0;
            end else begin
                stall = (k % 20) < 5;
                flush = (k % 50) == 0;
                if (k > 0 && k % 10 == 0) begin
                    automatic int j = (k / 10) % 7;
                    automatic logic [63:0] t = e1[j];
                    e1[j] = e1[j+1];
                    e1[j+1] = t;
                end
            end
            @(negedge clk);
            k++;
            if (k == 3) check("mid_run_flags", {busy, done, core_reset}, 3'b100);
        end
        start = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        check("run_bound", done, 1);
        cycles = k;
    endtask

    task automatic run2(input vec_t v, input bit exp_pass);
        int k = 0;
        load2(v);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("d2_restart_cnt", cycle_cnt2, 0);
        check("d2_restart_flags", {pass2, timeout2}, 0);
        repeat (2) @(negedge clk);
        check("d2_core_reset", core_reset2, 0);
        while (!done2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("d2_cycles", k, 20);
        check("d2_cycle_cnt", cycle_cnt2, 20);
        check("d2_pass", pass2, exp_pass);
        check("d2_timeout", timeout2, !exp_pass);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        load1_ramp(1'b1);
        load2('{1, 2, 3, 4, 5, 6, 7, 8});
        repeat (3) @(negedge clk);
        check("por_core_reset", core_reset, 1);
        check("por_flags", {busy, done, pass, timeout}, 0);
        check("por_cnt", {cycle_cnt, stall_cnt}, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_core_reset", core_reset, 1);
        check("idle_flags", {busy, done, pass, timeout}, 0);
        check("idle_flush_cnt", flush_cnt, 0);

        start1();
        run1(100, 0, n);
        check("sorted_latency", n, 17);
        check("sorted_cycle_cnt", cycle_cnt, 17);
        check("sorted_pass", pass, 1);
        check("sorted_timeout", timeout, 0);
        check("sorted_busy", busy, 0);

        load1_ramp(1'b0);
        start1();
        run1(800, 1, n);
        check("unsorted_cycles", n, 700);
        check("unsorted_cycle_cnt", cycle_cnt, 700);
        check("unsorted_timeout", timeout, 1);
        check("unsorted_pass", pass, 0);
        check("stall_cnt", stall_cnt, 175);
        check("flush_cnt", flush_cnt, 14);
        stall = 1'b1;
        flush = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        check("done_frozen_cnt", cycle_cnt, 700);
        check("done_frozen_stall", stall_cnt, 175);
        check("done_frozen_flush", flush_cnt, 14);
        check("done_core_reset", core_reset, 0);
        check("done_flag", done, 1);

        load1_ramp(1'b1);
        start1();
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_core_reset", core_reset, 1);
        check("async_flags", {busy, done, pass, timeout}, 0);
        check("async_cycle_cnt", cycle_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("after_reset_idle", {busy, core_reset}, 2'b01);
        start1();
        run1(100, 0, n);
        check("rerun_latency", n, 17);
        check("rerun_pass", pass, 1);

        run2('{-1, -1, -5, -6, -7, -8, -9, -10}, 1'b1);
        run2('{5, 3, -1, -1, -5, -7, -8, -9}, 1'b1);
        run2('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
